// File: rtl/note_detector.sv
// Square-wave period meter: synchronizes an asynchronous input, measures rising-edge
// spacing and decodes it into a one-hot note A..G with lock, change and raw-period outputs.
module note_detector #(
   parameter int CLK_MHZ      = 25,
   parameter int A_FREQ       = 220,
   parameter int B_FREQ       = 247,
   parameter int C_FREQ       = 261,
   parameter int D_FREQ       = 294,
   parameter int E_FREQ       = 330,
   parameter int F_FREQ       = 349,
   parameter int G_FREQ       = 392,
   parameter int TOL_SHIFT    = 6,
   parameter int STABLE_COUNT = 3,
   parameter int TIMEOUT      = 262144
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        soundWave,
   output logic [6:0]  noteOut,
   output logic        noteValid,
   output logic        noteChange,
   output logic [19:0] period
);

   localparam int            SW      = $clog2(STABLE_COUNT + 1);
   localparam logic [SW-1:0] STABLE  = SW'(STABLE_COUNT);
   localparam logic [19:0]   CNT_MAX = 20'hFFFFF;
   localparam logic [19:0]   TMO     = 20'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

   // Bit position in noteOut: bit 6 is A down to bit 0 is G.
   function automatic int freq_of(input int b);
      case (b)
         6:       return A_FREQ;
         5:       return B_FREQ;
         4:       return C_FREQ;
         3:       return D_FREQ;
         2:       return E_FREQ;
         1:       return F_FREQ;
         default: return G_FREQ;
      endcase
   endfunction

   // Notes that take priority over note b when both match: lower frequency, ties to the A side.
   function automatic logic [6:0] priority_over(input int b);
      logic [6:0] m;
      m = '0;
      for (int j = 0; j < 7; j++)
         if (freq_of(j) < freq_of(b) || (freq_of(j) == freq_of(b) && j > b))
            m[j] = 1'b1;
      return m;
   endfunction

   logic          r_sync1, r_sync2, r_sync3;
   logic [19:0]   r_cnt;
   state_t        r_state;
   logic [SW-1:0] r_streak;
   logic [6:0]    r_cand;

   logic          w_strobe, w_timeout, w_hit, w_same, w_lock;
   logic [6:0]    w_match, w_sel, w_note_next;
   logic [SW-1:0] w_streak_next;
   logic [31:0]   w_p;

   assign w_strobe  = r_sync2 & ~r_sync3;
   assign w_timeout = (r_cnt == TMO) && !w_strobe;
   assign w_p       = {12'd0, r_cnt};

   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_note
         localparam logic [31:0] NOM  = 32'(2 * ((CLK_MHZ * 1000000 / freq_of(gi) / 2) + 1));
         localparam logic [31:0] TOL  = NOM >> TOL_SHIFT;
         localparam logic [6:0]  PRIO = priority_over(gi);
         assign w_match[gi] = (r_cnt != CNT_MAX) && (w_p + TOL >= NOM) && (w_p <= NOM + TOL);
         assign w_sel[gi]   = w_match[gi] && ((w_match & PRIO) == 7'd0);
      end
   endgenerate

   assign w_hit  = |w_sel;
   assign w_same = (r_streak != '0) && (w_sel == r_cand);

   always_comb begin
      w_streak_next = r_streak;
      if (!w_hit)
         w_streak_next = '0;
      else if (!w_same)
         w_streak_next = SW'(1);
      else if (r_streak < STABLE)
         w_streak_next = r_streak + 1'b1;
      w_lock = w_hit && (w_streak_next == STABLE);

      w_note_next = noteOut;
      if (w_strobe && r_state != IDLE && w_lock)
         w_note_next = w_sel;
      else if (w_timeout)
         w_note_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_sync3    <= 1'b0;
         r_cnt      <= '0;
         r_state    <= IDLE;
         r_streak   <= '0;
         r_cand     <= '0;
         noteOut    <= '0;
         noteValid  <= 1'b0;
         noteChange <= 1'b0;
         period     <= '0;
      end else begin
         r_sync1 <= soundWave;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;

         if (w_strobe)
            r_cnt <= 20'd1;
         else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 20'd1;

         noteOut    <= w_note_next;
         noteValid  <= |w_note_next;
         noteChange <= (w_note_next != noteOut);

         // The first edge out of IDLE only aligns the counter; its period is meaningless.
         if (w_strobe) begin
            if (r_state == IDLE) begin
               r_state <= MEASURE;
            end else begin
               period   <= r_cnt;
               r_streak <= w_streak_next;
               if (w_hit)
                  r_cand <= w_sel;
               if (w_lock)
                  r_state <= LOCKED;
            end
         end else if (w_timeout) begin
            r_state  <= IDLE;
            r_streak <= '0;
         end
      end
   end

endmodule
